// File: rtl/hex_display_scan.sv
// Hex display driver: captures a value on load and commits it to the display only at a scan-frame wrap.
// Optional leading-zero blanking when HEXDISP_BLANK_LZ_EN is defined.
module hex_display_scan #(
    parameter int DIGITS   = 6,
    parameter int SCAN_DIV = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    output logic [7*DIGITS-1:0]   hex_all,
    output logic [6:0]            seg_n,
    output logic [DIGITS-1:0]     dig_n,
    output logic                  frame_done,
    output logic                  pending
);

    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PSW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    logic [PSW-1:0]        r_prescaler;
    logic [IDXW-1:0]       r_idx;
    logic [4*DIGITS-1:0]   r_cap;
    logic [4*DIGITS-1:0]   r_shadow;
    logic                  r_pending;
    logic [7*DIGITS-1:0]   r_hex_all;
    logic [6:0]            r_seg_n;
    logic [DIGITS-1:0]     r_dig_n;
    logic                  r_frame_done;

    logic                  w_tick;
    logic                  w_wrap;
    logic [6:0]            w_digit_code [DIGITS];
    logic [7*DIGITS-1:0]   w_hex_all;
    logic [DIGITS-1:0]     w_dig_n;

    function automatic logic [6:0] seg_code(input logic [3:0] nib);
        case (nib)
            4'h0: seg_code = 7'h01;
            4'h1: seg_code = 7'h4F;
            4'h2: seg_code = 7'h12;
            4'h3: seg_code = 7'h06;
            4'h4: seg_code = 7'h4C;
            4'h5: seg_code = 7'h24;
            4'h6: seg_code = 7'h20;
            4'h7: seg_code = 7'h0F;
            4'h8: seg_code = 7'h00;
            4'h9: seg_code = 7'h0C;
            4'hA: seg_code = 7'h08;
            4'hB: seg_code = 7'h60;
            4'hC: seg_code = 7'h31;
            4'hD: seg_code = 7'h42;
            4'hE: seg_code = 7'h30;
            default: seg_code = 7'h38;
        endcase
    endfunction

    assign w_tick = (r_prescaler == PSW'(SCAN_DIV - 1));
    assign w_wrap = w_tick && (r_idx == IDXW'(DIGITS - 1));

`ifdef HEXDISP_BLANK_LZ_EN
    logic [IDXW-1:0] w_msd;

    // Position of the most-significant nonzero nibble; stays 0 for an all-zero value.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_msd = '0;
        for (int i = 1; i < DIGITS; i++) begin
            if (r_shadow[4*i +: 4] != 4'h0) w_msd = IDXW'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            w_digit_code[i] = (i > int'(w_msd)) ? SEG_BLANK : seg_code(r_shadow[4*i +: 4]);
        end
    end
`else
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            w_digit_code[i] = seg_code(r_shadow[4*i +: 4]);
        end
    end
`endif

    always_comb begin
        w_hex_all = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_hex_all[7*i +: 7] = w_digit_code[i];
        end
    end

    assign w_dig_n = ~(DIGITS'(1) << r_idx);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_prescaler  <= '0;
            r_idx        <= '0;
            r_cap        <= '0;
            r_shadow     <= '0;
            r_pending    <= 1'b0;
            r_hex_all    <= {DIGITS{SEG_BLANK}};
            r_seg_n      <= SEG_BLANK;
            r_dig_n      <= '1;
            r_frame_done <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            r_prescaler <= w_tick ? '0 : r_prescaler + PSW'(1);
            if (w_tick) r_idx <= w_wrap ? '0 : r_idx + IDXW'(1);
            r_frame_done <= w_wrap;

            if (load) r_cap <= value;

            // A load landing on the wrap cycle goes straight to the display.
            if (w_wrap) begin
                if (load)           r_shadow <= value;
                else if (r_pending) r_shadow <= r_cap;
                r_pending <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end

            r_hex_all <= w_hex_all;
            r_seg_n   <= w_digit_code[r_idx];
            r_dig_n   <= w_dig_n;
        end
    end

    assign hex_all    = r_hex_all;
    assign seg_n      = r_seg_n;
    assign dig_n      = r_dig_n;
    assign frame_done = r_frame_done;
    assign pending    = r_pending;

endmodule

// File: tb/tb_hex_display_scan.sv
// Directed bench for hex_display_scan (DIGITS=6, SCAN_DIV=4): scan timing, tear-free commit, reset.
module tb_hex_display_scan;

    localparam int DIGITS   = 6;
    localparam int SCAN_DIV = 4;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    localparam logic [41:0] BLANK_DISP = {6{7'h7F}};
`ifdef HEXDISP_BLANK_LZ_EN
    localparam logic [41:0] ZERO_DISP  = {{5{7'h7F}}, 7'h01};
    localparam logic [41:0] SEVEN_DISP = {{5{7'h7F}}, 7'h0F};
`else
    localparam logic [41:0] ZERO_DISP  = {6{7'h01}};
    localparam logic [41:0] SEVEN_DISP = {{5{7'h01}}, 7'h0F};
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] value = '0;
    logic        load  = 1'b0;
    logic [41:0] hex_all;
    logic [6:0]  seg_n;
    logic [5:0]  dig_n;
    logic        frame_done;
    logic        pending;

    hex_display_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clock      (clock),
        .reset      (reset),
        .value      (value),
        .load       (load),
        .hex_all    (hex_all),
        .seg_n      (seg_n),
        .dig_n      (dig_n),
        .frame_done (frame_done),
        .pending    (pending)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        use_pre;
        logic [23:0] pre;
        logic [23:0] val;
        logic [41:0] exp;
    } vec_t;

    vec_t vecs [5];
    int   total = 0;
    int   bad   = 0;
    int   k     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, k);
        end
    endtask

    function automatic int cur_digit(input int kk);
        return ((kk - 1) / SCAN_DIV) % DIGITS;
    endfunction

    // One clock after reset release; the scan position follows from the cycle count alone.
    task automatic step();
        logic [5:0] exp_dig;
        @(posedge clock);
        #1;
        k++;
        exp_dig = ~(6'(1) << cur_digit(k));
        check("dig_n", 64'(dig_n), 64'(exp_dig));
        check("frame_done", 64'(frame_done), 64'(k % FRAME == 0));
    endtask

    task automatic check_blank(input string tag);
        check({tag, "_hex_all"}, 64'(hex_all), 64'(BLANK_DISP));
        check({tag, "_seg_n"}, 64'(seg_n), 64'h7F);
        check({tag, "_dig_n"}, 64'(dig_n), 64'h3F);
        check({tag, "_frame_done"}, 64'(frame_done), 64'h0);
        check({tag, "_pending"}, 64'(pending), 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [41:0] prev;
        logic [41:0] e;
        logic        found;

`ifdef HEXDISP_BLANK_LZ_EN
        vecs[0] = '{1'b0, 24'h0, 24'h00123A, {7'h7F, 7'h7F, 7'h4F, 7'h12, 7'h06, 7'h08}};
        vecs[3] = '{1'b0, 24'h0, 24'h000050, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h24, 7'h01}};
        vecs[4] = '{1'b0, 24'h0, 24'h000000, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h01}};
`else
        vecs[0] = '{1'b0, 24'h0, 24'h00123A, {7'h01, 7'h01, 7'h4F, 7'h12, 7'h06, 7'h08}};
        vecs[3] = '{1'b0, 24'h0, 24'h000050, {7'h01, 7'h01, 7'h01, 7'h01, 7'h24, 7'h01}};
        vecs[4] = '{1'b0, 24'h0, 24'h000000, {7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01}};
`endif
        vecs[1] = '{1'b1, 24'h111111, 24'hFEDCBA, {7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08}};
        vecs[2] = '{1'b0, 24'h0, 24'h987654, {7'h0C, 7'h00, 7'h0F, 7'h20, 7'h24, 7'h4C}};

        // Reset held three cycles: everything blank.
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_blank("reset");

        // First cycle after release shows digit 0 of a zero shadow; then two full frames.
        reset = 1'b0;
        k = 0;
        step();
        check("first_hex_all", 64'(hex_all), 64'(ZERO_DISP));
        check("first_seg_n", 64'(seg_n), 64'h01);
        repeat (2 * FRAME - 1) step();
        prev = ZERO_DISP;

        for (int i = 0; i < 5; i++) begin
            while (k % FRAME != 5) step();
            load = 1'b1;
            if (vecs[i].use_pre) begin
                value = vecs[i].pre;
                step();
            end
            value = vecs[i].val;
            step();
            load = 1'b0;
            check("load_pending", 64'(pending), 64'h1);
            check("load_hold", 64'(hex_all), 64'(prev));

            found = 1'b0;
            for (int n = 0; n < FRAME + 4 && !found; n++) begin
                step();
                if (frame_done) found = 1'b1;
                else check("wait_hold", 64'(hex_all), 64'(prev));
            end
            check("wrap_seen", 64'(found), 64'h1);
            check("wrap_pending", 64'(pending), 64'h0);
            check("wrap_hold", 64'(hex_all), 64'(prev));

            e = vecs[i].exp;
            repeat (FRAME) begin
                step();
                check("vec_hex_all", 64'(hex_all), 64'(e));
                check("vec_seg_n", 64'(seg_n), 64'(e[7*cur_digit(k) +: 7]));
            end
            prev = e;
        end

        // Load landing on the wrap cycle commits immediately and never raises pending.
        while (k % FRAME != FRAME - 1) step();
        load  = 1'b1;
        value = 24'h000007;
        step();
        load = 1'b0;
        check("coinc_pending", 64'(pending), 64'h0);
        check("coinc_hold", 64'(hex_all), 64'(prev));
        step();
        check("coinc_hex_all", 64'(hex_all), 64'(SEVEN_DISP));
        check("coinc_seg_n", 64'(seg_n), 64'h0F);
        check("coinc_pending2", 64'(pending), 64'h0);

        // Reset mid-frame at digit 3 with a capture pending: it is discarded.
        while (k % FRAME != 13) step();
        load  = 1'b1;
        value = 24'hABCDEF;
        step();
        load = 1'b0;
        check("pre_rst_pending", 64'(pending), 64'h1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_blank("midrst");
        reset = 1'b0;
        k = 0;
        step();
        check("rst_hex_all", 64'(hex_all), 64'(ZERO_DISP));
        check("rst_seg_n", 64'(seg_n), 64'h01);
        repeat (FRAME) step();
        check("rst_after_wrap", 64'(hex_all), 64'(ZERO_DISP));
        check("rst_pending", 64'(pending), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
